// File: rtl/iter_div_unit.sv
// Multicycle restoring radix-2 integer divider for the EX stage.
// Signed/unsigned modes, divide-by-zero fast path, result held in DONE until the pipeline accepts it.
module iter_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               req_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               accept_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               hilo_we_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        SIGN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_nextState;

    logic               r_signedMode;
    logic               r_dvdNeg;
    logic               r_dsrNeg;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;
    logic [CNT_W-1:0]   r_count;

    logic               w_divByZero;
    logic [WIDTH-1:0]   w_dvdAbs;
    logic [WIDTH-1:0]   w_dsrAbs;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_trial;

    assign w_divByZero = (divisor_i == '0);
    assign w_dvdAbs    = (signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
    assign w_dsrAbs    = (signed_i && divisor_i[WIDTH-1])  ? (~divisor_i + 1'b1)  : divisor_i;

    // r_quot doubles as the dividend shift register: its MSB feeds the partial remainder each step.
    assign w_remShift  = {r_rem, r_quot[WIDTH-1]};
    assign w_trial     = w_remShift - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush_i) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        w_nextState = w_divByZero ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (r_count == LAST_CNT) begin
                        w_nextState = SIGN;
                    end
                end
                SIGN: begin
                    w_nextState = DONE;
                end
                DONE: begin
                    if (accept_i || !req_i) begin
                        w_nextState = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // A flush freezes the datapath; whatever it last held stays visible until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signedMode <= 1'b0;
            r_dvdNeg     <= 1'b0;
            r_dsrNeg     <= 1'b0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_divisor    <= '0;
            r_count      <= '0;
        end else if (!flush_i) begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_signedMode <= signed_i;
                        r_dvdNeg     <= dividend_i[WIDTH-1];
                        r_dsrNeg     <= divisor_i[WIDTH-1];
                        r_count      <= '0;
                        if (w_divByZero) begin
                            r_quot <= '1;
                            r_rem  <= dividend_i;
                        end else begin
                            r_quot    <= w_dvdAbs;
                            r_rem     <= '0;
                            r_divisor <= w_dsrAbs;
                        end
                    end
                end
                BUSY: begin
                    r_rem   <= w_trial[WIDTH] ? w_remShift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_quot  <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_count <= r_count + 1'b1;
                end
                SIGN: begin
                    if (r_signedMode && (r_dvdNeg ^ r_dsrNeg)) begin
                        r_quot <= ~r_quot + 1'b1;
                    end
                    if (r_signedMode && r_dvdNeg) begin
                        r_rem <= ~r_rem + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o      = (r_state == BUSY) || (r_state == SIGN);
    assign done_o      = (r_state == DONE);
    assign stall_o     = req_i && !flush_i && (r_state != DONE);
    assign hilo_we_o   = done_o && accept_i && !flush_i;
    assign quotient_o  = r_quot;
    assign remainder_o = r_rem;
    assign result_o    = {r_rem, r_quot};

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed scenarios plus randomized operations
// checked against a plain-arithmetic division model, at WIDTH=32 and WIDTH=8.
module tb_iter_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushI;
    logic        reqI;
    logic        signedI;
    logic [31:0] dividendI;
    logic [31:0] divisorI;
    logic        acceptI;
    logic        stallO;
    logic        busyO;
    logic        doneO;
    logic [31:0] quotientO;
    logic [31:0] remainderO;
    logic [63:0] resultO;
    logic        hiloWeO;

    logic        flush8;
    logic        req8;
    logic        signed8;
    logic [7:0]  dividend8;
    logic [7:0]  divisor8;
    logic        accept8;
    logic        stall8;
    logic        busy8;
    logic        done8;
    logic [7:0]  quotient8;
    logic [7:0]  remainder8;
    logic [15:0] result8;
    logic        hiloWe8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iter_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flushI), .req_i(reqI), .signed_i(signedI),
        .dividend_i(dividendI), .divisor_i(divisorI), .accept_i(acceptI),
        .stall_o(stallO), .busy_o(busyO), .done_o(doneO), .quotient_o(quotientO),
        .remainder_o(remainderO), .result_o(resultO), .hilo_we_o(hiloWeO)
    );

    iter_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush_i(flush8), .req_i(req8), .signed_i(signed8),
        .dividend_i(dividend8), .divisor_i(divisor8), .accept_i(accept8),
        .stall_o(stall8), .busy_o(busy8), .done_o(done8), .quotient_o(quotient8),
        .remainder_o(remainder8), .result_o(result8), .hilo_we_o(hiloWe8)
    );

    // Reference: truncating division as the ISA defines it; zero divisor yields all-ones / raw dividend.
    function automatic logic [63:0] refDiv32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [15:0] refDiv8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, q, r;
        if (b == 0) return {a, 8'hFF};
        if (!sgn) return {a % b, a / b};
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[7:0], q[7:0]};
    endfunction

    // Runs one 32-bit operation with accept high; operands are scrambled after cycle 0 to prove they are ignored.
    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic [63:0] res,
                                 output int lat, output int weCount, output int busyCount);
        q = '0; r = '0; res = '0; lat = -1; weCount = 0; busyCount = 0;
        @(posedge clk); #1;
        signedI = sgn; dividendI = a; divisorI = b; acceptI = 1'b1; reqI = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 1) begin
                dividendI = $urandom; divisorI = $urandom; signedI = ~sgn;
            end
            #1;
            if (hiloWeO) weCount++;
            if (busyO) busyCount++;
            if (doneO) begin
                lat = c; q = quotientO; r = remainderO; res = resultO;
                break;
            end
        end
        @(posedge clk); #1;
        reqI = 1'b0;
    endtask

    task automatic applyStimulus8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic [15:0] res,
                                  output int lat);
        q = '0; r = '0; res = '0; lat = -1;
        @(posedge clk); #1;
        signed8 = sgn; dividend8 = a; divisor8 = b; accept8 = 1'b1; req8 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 1) begin
                dividend8 = 8'($urandom); divisor8 = 8'($urandom);
            end
            #1;
            if (done8) begin
                lat = c; q = quotient8; r = remainder8; res = result8;
                break;
            end
        end
        @(posedge clk); #1;
        req8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flushI = 1'b0; reqI = 1'b0; signedI = 1'b0; dividendI = '0; divisorI = '0; acceptI = 1'b0;
        flush8 = 1'b0; req8 = 1'b0; signed8 = 1'b0; dividend8 = '0; divisor8 = '0; accept8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({busyO, doneO, hiloWeO, stallO} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {busyO, doneO, hiloWeO, stallO});
        end
        total++;
        if (resultO !== 64'h0 || quotientO !== 32'h0 || remainderO !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_result got=%h want=0", resultO);
        end
        total++;
        if ({busy8, done8, hiloWe8, stall8} !== 4'b0000 || result8 !== 16'h0) begin
            bad++; $display("[TB] FAIL reset_w8 got=%b/%h want=0000/0", {busy8, done8, hiloWe8, stall8}, result8);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;
        total++;
        if (stallO !== 1'b0 || busyO !== 1'b0) begin
            bad++; $display("[TB] FAIL idle_no_stall got stall=%b busy=%b want 0/0", stallO, busyO);
        end
    endtask

    task automatic test_unsigned_latency();
        @(posedge clk); #1;
        signedI = 1'b0; dividendI = 32'd100; divisorI = 32'd7; acceptI = 1'b1; reqI = 1'b1;
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 35) reqI = 1'b0;
            #1;
            total++;
            if (stallO !== 1'(c <= 33)) begin
                bad++; $display("[TB] FAIL lat_stall cycle=%0d got=%b want=%b", c, stallO, 1'(c <= 33));
            end
            total++;
            if (doneO !== 1'(c == 34) || hiloWeO !== 1'(c == 34)) begin
                bad++; $display("[TB] FAIL lat_done cycle=%0d got done=%b we=%b want %b", c, doneO, hiloWeO, 1'(c == 34));
            end
            if (c == 34) begin
                total++;
                if (quotientO !== 32'd14 || remainderO !== 32'd2) begin
                    bad++; $display("[TB] FAIL lat_value got q=%0d r=%0d want q=14 r=2", quotientO, remainderO);
                end
            end
        end
    endtask

    task automatic test_signed_cases();
        logic [31:0] tabA [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tabB [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bit          tabS [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] tabQ [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0};
        logic [31:0] tabR [4] = '{32'hFFFF_FFFF, 32'd1, 32'h0, 32'h8000_0000};
        logic [31:0] q, r;
        logic [63:0] res;
        int lat, we, bsy;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(tabS[i], tabA[i], tabB[i], q, r, res, lat, we, bsy);
            total++;
            if (q !== tabQ[i] || r !== tabR[i]) begin
                bad++; $display("[TB] FAIL signed_case%0d got q=%h r=%h want q=%h r=%h", i, q, r, tabQ[i], tabR[i]);
            end
            total++;
            if (lat !== 34 || we !== 1) begin
                bad++; $display("[TB] FAIL signed_timing%0d got lat=%0d we=%0d want 34/1", i, lat, we);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        logic [63:0] res;
        int lat, we, bsy;
        applyStimulus(1'b0, 32'h1234, 32'h0, q, r, res, lat, we, bsy);
        total++;
        if (lat !== 1 || bsy !== 0) begin
            bad++; $display("[TB] FAIL dz_timing got lat=%0d busy=%0d want 1/0", lat, bsy);
        end
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234) begin
            bad++; $display("[TB] FAIL dz_value got q=%h r=%h want FFFFFFFF/1234", q, r);
        end
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0, q, r, res, lat, we, bsy);
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF9 || lat !== 1) begin
            bad++; $display("[TB] FAIL dz_signed got q=%h r=%h lat=%0d want FFFFFFFF/FFFFFFF9/1", q, r, lat);
        end
    endtask

    task automatic test_flush();
        int doneAt = -1;
        int wePulses = 0;
        @(posedge clk); #1;
        signedI = 1'b0; dividendI = 32'd1000; divisorI = 32'd3; acceptI = 1'b1; reqI = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            flushI = (c == 10);
            #1;
            if (c == 10) begin
                total++;
                if (stallO !== 1'b0 || hiloWeO !== 1'b0) begin
                    bad++; $display("[TB] FAIL flush_cycle got stall=%b we=%b want 0/0", stallO, hiloWeO);
                end
            end
            if (c == 11) begin
                total++;
                if (busyO !== 1'b0 || doneO !== 1'b0) begin
                    bad++; $display("[TB] FAIL flush_idle got busy=%b done=%b want 0/0", busyO, doneO);
                end
            end
            if (hiloWeO && !doneO) wePulses++;
            if (doneO) begin
                doneAt = c;
                total++;
                if (quotientO !== 32'd333 || remainderO !== 32'd1) begin
                    bad++; $display("[TB] FAIL flush_rerun_value got q=%0d r=%0d want 333/1", quotientO, remainderO);
                end
                break;
            end
        end
        total++;
        if (doneAt !== 45 || wePulses !== 0) begin
            bad++; $display("[TB] FAIL flush_rerun_latency got done=%0d stray_we=%0d want 45/0", doneAt, wePulses);
        end
        @(posedge clk); #1;
        reqI = 1'b0;
        // flush in the same cycle as a request in IDLE must not start anything
        @(posedge clk); #1;
        dividendI = 32'd55; divisorI = 32'd0; reqI = 1'b1; flushI = 1'b1;
        #1;
        total++;
        if (stallO !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_req_stall got=%b want=0", stallO);
        end
        @(posedge clk); #1;
        reqI = 1'b0; flushI = 1'b0;
        #1;
        total++;
        if (busyO !== 1'b0 || doneO !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_req_start got busy=%b done=%b want 0/0", busyO, doneO);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] q, r;
        logic [63:0] res;
        int lat, we, bsy;
        @(posedge clk); #1;
        signedI = 1'b1; dividendI = 32'hFFFF_0000; divisorI = 32'd17; acceptI = 1'b1; reqI = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1; reqI = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({busyO, doneO, hiloWeO, stallO} !== 4'b0000 || resultO !== 64'h0) begin
            bad++; $display("[TB] FAIL rst_busy got flags=%b res=%h want 0000/0", {busyO, doneO, hiloWeO, stallO}, resultO);
        end
        applyStimulus(1'b0, 32'd12345, 32'd17, q, r, res, lat, we, bsy);
        total++;
        if (lat !== 34 || q !== 32'd726 || r !== 32'd3) begin
            bad++; $display("[TB] FAIL rst_rerun got lat=%0d q=%0d r=%0d want 34/726/3", lat, q, r);
        end
    endtask

    task automatic test_accept_hold();
        int doneAt = -1;
        @(posedge clk); #1;
        signedI = 1'b0; dividendI = 32'd50000; divisorI = 32'd9; acceptI = 1'b0; reqI = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            #1;
            if (doneO) begin doneAt = c; break; end
        end
        total++;
        if (doneAt !== 34) begin
            bad++; $display("[TB] FAIL hold_latency got=%0d want=34", doneAt);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            total++;
            if (doneO !== 1'b1 || stallO !== 1'b0 || hiloWeO !== 1'b0 ||
                quotientO !== 32'd5555 || remainderO !== 32'd5) begin
                bad++; $display("[TB] FAIL hold_k%0d got done=%b stall=%b we=%b q=%0d r=%0d want 1/0/0/5555/5",
                                k, doneO, stallO, hiloWeO, quotientO, remainderO);
            end
        end
        @(posedge clk); #1;
        acceptI = 1'b1;
        #1;
        total++;
        if (hiloWeO !== 1'b1 || doneO !== 1'b1) begin
            bad++; $display("[TB] FAIL hold_accept got we=%b done=%b want 1/1", hiloWeO, doneO);
        end
        @(posedge clk); #1;
        total++;
        if (doneO !== 1'b0 || busyO !== 1'b0 || hiloWeO !== 1'b0) begin
            bad++; $display("[TB] FAIL hold_release got done=%b busy=%b we=%b want 0/0/0", doneO, busyO, hiloWeO);
        end
        reqI = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          doneCycles [$];
        logic [63:0] doneVals   [$];
        @(posedge clk); #1;
        signedI = 1'b0; dividendI = 32'd200000; divisorI = 32'd13; acceptI = 1'b1; reqI = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 35) begin
                signedI = 1'b1; dividendI = 32'hFFFF_FC18; divisorI = 32'd7;
            end
            if (doneCycles.size() == 2) reqI = 1'b0;
            #1;
            if (c == 35) begin
                total++;
                if (busyO !== 1'b0 || stallO !== 1'b1) begin
                    bad++; $display("[TB] FAIL b2b_gap got busy=%b stall=%b want 0/1", busyO, stallO);
                end
            end
            if (doneO) begin
                doneCycles.push_back(c);
                doneVals.push_back({remainderO, quotientO});
            end
            if (doneCycles.size() == 2 && !reqI) break;
        end
        total++;
        if (doneCycles.size() != 2) begin
            bad++; $display("[TB] FAIL b2b_count got=%0d want=2", doneCycles.size());
        end else begin
            total++;
            if (doneCycles[0] !== 34 || doneCycles[1] !== 69) begin
                bad++; $display("[TB] FAIL b2b_timing got=%0d,%0d want=34,69", doneCycles[0], doneCycles[1]);
            end
            total++;
            if (doneVals[0] !== refDiv32(1'b0, 32'd200000, 32'd13) ||
                doneVals[1] !== refDiv32(1'b1, 32'hFFFF_FC18, 32'd7)) begin
                bad++; $display("[TB] FAIL b2b_value got=%h,%h want=%h,%h", doneVals[0], doneVals[1],
                                refDiv32(1'b0, 32'd200000, 32'd13), refDiv32(1'b1, 32'hFFFF_FC18, 32'd7));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r;
        logic [63:0] res, want;
        bit sgn;
        int lat, we, bsy;
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = -($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            want = refDiv32(sgn, a, b);
            applyStimulus(sgn, a, b, q, r, res, lat, we, bsy);
            total++;
            if ({r, q} !== want || res !== want) begin
                bad++; $display("[TB] FAIL rand%0d s=%0d a=%h b=%h got q=%h r=%h res=%h want=%h", i, sgn, a, b, q, r, res, want);
            end
            total++;
            if (lat !== ((b == 0) ? 1 : 34) || we !== 1) begin
                bad++; $display("[TB] FAIL rand_timing%0d got lat=%0d we=%0d want %0d/1", i, lat, we, (b == 0) ? 1 : 34);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0]  a, b, q, r;
        logic [15:0] res, want;
        bit sgn;
        int lat;
        applyStimulus8(1'b0, 8'd200, 8'd3, q, r, res, lat);
        total++;
        if (q !== 8'd66 || r !== 8'd2 || lat !== 10) begin
            bad++; $display("[TB] FAIL w8_basic got q=%0d r=%0d lat=%0d want 66/2/10", q, r, lat);
        end
        applyStimulus8(1'b1, 8'h80, 8'hFF, q, r, res, lat);
        total++;
        if (q !== 8'h80 || r !== 8'h00) begin
            bad++; $display("[TB] FAIL w8_overflow got q=%h r=%h want 80/00", q, r);
        end
        for (int i = 0; i < 16; i++) begin
            sgn  = 1'($urandom);
            a    = 8'($urandom);
            b    = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
            want = refDiv8(sgn, a, b);
            applyStimulus8(sgn, a, b, q, r, res, lat);
            total++;
            if ({r, q} !== want || res !== want || lat !== ((b == 0) ? 1 : 10)) begin
                bad++; $display("[TB] FAIL w8_rand%0d s=%0d a=%h b=%h got=%h lat=%0d want=%h", i, sgn, a, b, res, lat, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed_cases();
        test_div_zero();
        test_flush();
        test_reset_busy();
        test_accept_hold();
        test_back_to_back();
        test_random();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before all tests completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
